gol_generation_sequencer: RTL and testbench

Sequencer that advances a WIDTH x HEIGHT Game of Life board by one generation per START request. It time-multiplexes one external 8-input neighbour popcount datapath across all cells, scanning one cell per cycle, and applies the birth/survival rule. It holds the current and next boards internally, commits the next board atomically, and provides host row load and read ports.

---
 rtl/gol_generation_sequencer.sv | 137 +++++++++++++
 tb/tb_gol_generation_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gol_generation_sequencer.sv
// Game of Life generation sequencer: scans one cell per cycle through a shared external popcount.
// Define GOL_WRAP_EN for a toroidal board; otherwise off-board neighbours read as dead.
module gol_generation_sequencer #(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      START,
   output logic                      BUSY,
   output logic                      DONE,
   output logic [15:0]               GEN_COUNT,
   input  logic                      LOAD_EN,
   input  logic [$clog2(HEIGHT)-1:0] LOAD_ROW,
   input  logic [WIDTH-1:0]          LOAD_DATA,
   input  logic [$clog2(HEIGHT)-1:0] RD_ROW,
   output logic [WIDTH-1:0]          RD_DATA,
   output logic                      PC_N,
   output logic                      PC_NE,
   output logic                      PC_E,
   output logic                      PC_SE,
   output logic                      PC_S,
   output logic                      PC_SW,
   output logic                      PC_W,
   output logic                      PC_NW,
   input  logic [3:0]                PC_COUNT
);

   localparam int RW = $clog2(HEIGHT);
   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SCAN   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]                    state;
   logic [RW-1:0]                 row_idx;
   logic [CW-1:0]                 col_idx;
   logic [HEIGHT-1:0][WIDTH-1:0]  cur_board;
   logic [HEIGHT-1:0][WIDTH-1:0]  next_board;
   logic                          scan_active;
   logic                          cur_bit;
   logic                          new_bit;

   function automatic logic cell_at(input int r, input int c);
      int rr;
      int cc;
`ifdef GOL_WRAP_EN
      rr = (r + HEIGHT) % HEIGHT;
      cc = (c + WIDTH) % WIDTH;
      return cur_board[rr[RW-1:0]][cc[CW-1:0]];
`else
      rr = r;
      cc = c;
      if (rr < 0 || rr >= HEIGHT || cc < 0 || cc >= WIDTH)
         return 1'b0;
      return cur_board[rr[RW-1:0]][cc[CW-1:0]];
`endif
   endfunction

   assign BUSY        = (state != S_IDLE);
   assign scan_active = (state == S_SCAN) && !RST;

   // Neighbour taps for the cursor cell; all forced low when not scanning.
   always_comb begin
      PC_N  = 1'b0;
      PC_NE = 1'b0;
      PC_E  = 1'b0;
      PC_SE = 1'b0;
      PC_S  = 1'b0;
      PC_SW = 1'b0;
      PC_W  = 1'b0;
      PC_NW = 1'b0;
      if (scan_active) begin
         PC_N  = cell_at(int'(row_idx) - 1, int'(col_idx));
         PC_NE = cell_at(int'(row_idx) - 1, int'(col_idx) + 1);
         PC_E  = cell_at(int'(row_idx),     int'(col_idx) + 1);
         PC_SE = cell_at(int'(row_idx) + 1, int'(col_idx) + 1);
         PC_S  = cell_at(int'(row_idx) + 1, int'(col_idx));
         PC_SW = cell_at(int'(row_idx) + 1, int'(col_idx) - 1);
         PC_W  = cell_at(int'(row_idx),     int'(col_idx) - 1);
         PC_NW = cell_at(int'(row_idx) - 1, int'(col_idx) - 1);
      end
   end

   assign cur_bit = cur_board[row_idx][col_idx];
   assign new_bit = (PC_COUNT == 4'd3) || (cur_bit && (PC_COUNT == 4'd2));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         row_idx    <= '0;
         col_idx    <= '0;
         cur_board  <= '0;
         next_board <= '0;
         DONE       <= 1'b0;
         GEN_COUNT  <= '0;
         RD_DATA    <= '0;
      end else begin
         DONE    <= 1'b0;
         RD_DATA <= (int'(RD_ROW) < HEIGHT) ? cur_board[RD_ROW] : '0;
         case (state)
            S_IDLE: begin
               if (LOAD_EN && (int'(LOAD_ROW) < HEIGHT))
                  cur_board[LOAD_ROW] <= LOAD_DATA;
               if (START) begin
                  state   <= S_SCAN;
                  row_idx <= '0;
                  col_idx <= '0;
               end
            end
            S_SCAN: begin
               next_board[row_idx][col_idx] <= new_bit;
               if (col_idx == CW'(WIDTH - 1)) begin
                  col_idx <= '0;
                  if (row_idx == RW'(HEIGHT - 1)) begin
                     row_idx <= '0;
                     state   <= S_COMMIT;
                  end else begin
                     row_idx <= row_idx + 1'b1;
                  end
               end else begin
                  col_idx <= col_idx + 1'b1;
               end
            end
            S_COMMIT: begin
               cur_board <= next_board;
               GEN_COUNT <= GEN_COUNT + 16'd1;
               DONE      <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gol_generation_sequencer.sv
// Directed bench for gol_generation_sequencer on an 8x8 board with a behavioural popcount.
// Corner-case expectations follow GOL_WRAP_EN when the bench is built with it.
module tb_gol_generation_sequencer;

   localparam int WIDTH  = 8;
   localparam int HEIGHT = 8;
   localparam int GEN_CYCLES = WIDTH * HEIGHT + 2;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        BUSY;
   logic        DONE;
   logic [15:0] GEN_COUNT;
   logic        LOAD_EN;
   logic [2:0]  LOAD_ROW;
   logic [7:0]  LOAD_DATA;
   logic [2:0]  RD_ROW;
   logic [7:0]  RD_DATA;
   logic        PC_N, PC_NE, PC_E, PC_SE, PC_S, PC_SW, PC_W, PC_NW;
   logic [3:0]  PC_COUNT;
   logic [7:0]  pc_vec;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   gol_generation_sequencer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
      .GEN_COUNT(GEN_COUNT), .LOAD_EN(LOAD_EN), .LOAD_ROW(LOAD_ROW),
      .LOAD_DATA(LOAD_DATA), .RD_ROW(RD_ROW), .RD_DATA(RD_DATA),
      .PC_N(PC_N), .PC_NE(PC_NE), .PC_E(PC_E), .PC_SE(PC_SE),
      .PC_S(PC_S), .PC_SW(PC_SW), .PC_W(PC_W), .PC_NW(PC_NW),
      .PC_COUNT(PC_COUNT)
   );

   always #5 CLK = ~CLK;

   // The popcount datapath the sequencer expects to sit beside it.
   assign PC_COUNT = {3'b0, PC_N} + {3'b0, PC_NE} + {3'b0, PC_E} + {3'b0, PC_SE}
                   + {3'b0, PC_S} + {3'b0, PC_SW} + {3'b0, PC_W} + {3'b0, PC_NW};
   assign pc_vec = {PC_N, PC_NE, PC_E, PC_SE, PC_S, PC_SW, PC_W, PC_NW};

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
      cycle++;
   endtask

   task automatic applyStimulus(input logic start_v, input logic load_v, input logic [2:0] row, input logic [7:0] data);
      START     = start_v;
      LOAD_EN   = load_v;
      LOAD_ROW  = row;
      LOAD_DATA = data;
   endtask

   task automatic do_reset;
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic load_row(input logic [2:0] row, input logic [7:0] data);
      applyStimulus(1'b0, 1'b1, row, data);
      tick();
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic check_board(input string tag, input logic [7:0][7:0] expected);
      for (int r = 0; r < HEIGHT; r++) begin
         RD_ROW = 3'(r);
         tick();
         checkOutput($sformatf("%s_row%0d", tag, r), {24'b0, RD_DATA}, {24'b0, expected[r]});
      end
   endtask

   // One generation from a START pulse; optionally probes the neighbour taps at one cycle.
   task automatic run_gen(input string tag, input int probe_cycle, input logic [7:0] probe_pc);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
      cycle = 0;
      tick();
      START = 1'b0;
      while (!DONE && cycle < 300) begin
         if (cycle == 1 || cycle == WIDTH * HEIGHT + 1)
            checkOutput($sformatf("%s_busy_c%0d", tag, cycle), {31'b0, BUSY}, 32'd1);
         if (cycle == probe_cycle)
            checkOutput($sformatf("%s_pc_c%0d", tag, cycle), {24'b0, pc_vec}, {24'b0, probe_pc});
         tick();
      end
      checkOutput({tag, "_done_cycle"}, cycle, GEN_CYCLES);
   endtask

   logic [7:0][7:0] expected_board;
   logic [7:0]      corner_pc;
   int              done_hits;
   int              first_done;

   initial begin
      RST    = 1'b0;
      RD_ROW = 3'd0;
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
      do_reset();

      // Reset state
      checkOutput("rst_busy", {31'b0, BUSY}, 32'd0);
      checkOutput("rst_done", {31'b0, DONE}, 32'd0);
      checkOutput("rst_gen", {16'b0, GEN_COUNT}, 32'd0);
      checkOutput("rst_pc", {24'b0, pc_vec}, 32'd0);
      checkOutput("rst_rd", {24'b0, RD_DATA}, 32'd0);
      check_board("rst", 64'h0);

      // Blinker oscillates horizontal -> vertical -> horizontal
      load_row(3'd3, 8'h1C);
      run_gen("blink1", 20, 8'b00011100);
      checkOutput("blink1_gen", {16'b0, GEN_COUNT}, 32'd1);
      expected_board = '0;
      expected_board[2] = 8'h08;
      expected_board[3] = 8'h08;
      expected_board[4] = 8'h08;
      check_board("blink1", expected_board);
      run_gen("blink2", -1, 8'h00);
      expected_board = '0;
      expected_board[3] = 8'h1C;
      check_board("blink2", expected_board);
      checkOutput("blink2_gen", {16'b0, GEN_COUNT}, 32'd2);

      // Still-life block, three generations chained via START in each DONE cycle
      do_reset();
      load_row(3'd3, 8'h18);
      load_row(3'd4, 8'h18);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
      cycle = 0;
      tick();
      START = 1'b0;
      for (int g = 1; g <= 3; g++) begin
         while (!DONE && cycle < 700)
            tick();
         checkOutput($sformatf("block_done%0d_cycle", g), cycle, GEN_CYCLES * g);
         if (g < 3)
            START = 1'b1;
         tick();
         START = 1'b0;
      end
      checkOutput("block_gen", {16'b0, GEN_COUNT}, 32'd3);
      expected_board = '0;
      expected_board[3] = 8'h18;
      expected_board[4] = 8'h18;
      check_board("block", expected_board);

      // Four corner cells
      do_reset();
      load_row(3'd0, 8'h81);
      load_row(3'd7, 8'h81);
      expected_board = '0;
`ifdef GOL_WRAP_EN
      expected_board[0] = 8'h81;
      expected_board[7] = 8'h81;
      corner_pc = 8'b10000011;
`else
      corner_pc = 8'b00000000;
`endif
      run_gen("corner", 1, corner_pc);
      check_board("corner", expected_board);

      // START and LOAD_EN during SCAN are both dropped
      do_reset();
      load_row(3'd3, 8'h1C);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
      cycle = 0;
      tick();
      START = 1'b0;
      while (cycle < 10)
         tick();
      applyStimulus(1'b1, 1'b1, 3'd0, 8'hFF);
      tick();
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00);
      done_hits  = 0;
      first_done = -1;
      while (cycle < 150) begin
         if (DONE) begin
            done_hits++;
            if (first_done < 0)
               first_done = cycle;
         end
         tick();
      end
      checkOutput("busyin_done_hits", done_hits, 32'd1);
      checkOutput("busyin_done_cycle", first_done, GEN_CYCLES);
      checkOutput("busyin_gen", {16'b0, GEN_COUNT}, 32'd1);
      expected_board = '0;
      expected_board[2] = 8'h08;
      expected_board[3] = 8'h08;
      expected_board[4] = 8'h08;
      check_board("busyin", expected_board);

      // Reset mid-SCAN abandons the generation
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00);
      cycle = 0;
      tick();
      START = 1'b0;
      while (cycle < 20)
         tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checkOutput("midrst_busy", {31'b0, BUSY}, 32'd0);
      checkOutput("midrst_done", {31'b0, DONE}, 32'd0);
      checkOutput("midrst_gen", {16'b0, GEN_COUNT}, 32'd0);
      checkOutput("midrst_pc", {24'b0, pc_vec}, 32'd0);
      done_hits = 0;
      for (int i = 0; i < 80; i++) begin
         if (DONE)
            done_hits++;
         tick();
      end
      checkOutput("midrst_done_hits", done_hits, 32'd0);
      check_board("midrst", 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
